// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the iterative restoring divider:
//     state_t      - FSM state encodings (IDLE / CALC / DONE), 2 bits
//     WL_DEFAULT   - default operand word length
//     CNT_W        - iteration counter width for the default word length
//     cnt_width()  - counter width for an arbitrary word length
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WL_DEFAULT = 32;
  localparam int CNT_W      = $clog2(WL_DEFAULT);

  function automatic int cnt_width(input int wl);
    return (wl > 1) ? $clog2(wl) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division stage.
//   Ports:
//     p_i      WL  current partial remainder (always < divisor, so WL bits suffice)
//     msb_i    1   next dividend bit shifted into the remainder
//     b_i      WL  divisor
//     p_o      WL  next partial remainder
//     qbit_o   1   quotient bit produced by this stage
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WL = 32
) (
  input  logic [WL-1:0] p_i,
  input  logic          msb_i,
  input  logic [WL-1:0] b_i,
  output logic [WL-1:0] p_o,
  output logic          qbit_o
);

  logic [WL:0] shifted;
  logic [WL:0] diff;

  // The shifted remainder can reach 2*B-1, so the trial subtraction needs
  // one extra bit; its sign bit says whether the divisor fit.
  assign shifted = {p_i, msb_i};
  assign diff    = shifted - {1'b0, b_i};
  assign qbit_o  = ~diff[WL];
  assign p_o     = qbit_o ? diff[WL-1:0] : shifted[WL-1:0];

endmodule

// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Sequential radix-2 restoring unsigned divider: Q = A / B, R = A % B,
//   one quotient bit per clock, with a start/done handshake.
//   Ports:
//     CLK       in   clock, rising edge
//     RST       in   synchronous reset, active-high
//     start     in   request, accepted when busy is low (IDLE or DONE)
//     A, B      in   WL  dividend / divisor, captured on the accepting edge
//     busy      out  high for the iterations of an operation
//     done      out  one-cycle pulse, results valid
//     Q, R      out  WL  quotient / remainder, held until the next done
//     div_zero  out  divisor was zero on the completed operation
//   Build option:
//     DIV_ZERO_SHORTCUT_EN - a zero divisor skips the iterations and completes
//     one cycle after acceptance. Without it a zero divisor runs all WL steps,
//     which naturally yields Q = all ones, R = A.
// -----------------------------------------------------------------------------
module iterative_divider
  import divider_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [WL-1:0] A,
  input  logic [WL-1:0] B,
  output logic          busy,
  output logic          done,
  output logic [WL-1:0] Q,
  output logic [WL-1:0] R,
  output logic          div_zero
);

  localparam int CW = cnt_width(WL);
  localparam logic [CW-1:0] LAST = CW'(WL - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [WL-1:0] p_q;
  // Holds the dividend; quotient bits shift in from the bottom as dividend
  // bits leave from the top, so after WL steps it holds the quotient.
  logic [WL-1:0] dq_q;
  logic [WL-1:0] b_q;
  logic          bz_q;
  logic          busy_q;
  logic          done_q;
  logic [WL-1:0] q_q;
  logic [WL-1:0] r_q;
  logic          dz_q;

  logic [WL-1:0] p_d;
  logic          qbit_d;
  logic [WL-1:0] dq_d;

  div_step #(.WL(WL)) u_step (
    .p_i    (p_q),
    .msb_i  (dq_q[WL-1]),
    .b_i    (b_q),
    .p_o    (p_d),
    .qbit_o (qbit_d)
  );

  assign dq_d = {dq_q[WL-2:0], qbit_d};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dq_q    <= A;
            b_q     <= B;
            p_q     <= '0;
            bz_q    <= (B == '0);
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
`ifdef DIV_ZERO_SHORTCUT_EN
          if (bz_q) begin
            // dq_q still holds the untouched dividend here.
            q_q     <= '1;
            r_q     <= dq_q;
            dz_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else
`endif
          begin
            p_q   <= p_d;
            dq_q  <= dq_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              q_q     <= dq_d;
              r_q     <= p_d;
              dz_q    <= bz_q;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
//   Self-checking bench for iterative_divider (WL = 32). A behavioural model
//   predicts busy/done/Q/R/div_zero from plain division and an operation
//   latency countdown; a compare process checks every cycle, and directed
//   sequences pin literal results and latencies.
// -----------------------------------------------------------------------------
module tb_iterative_divider;

  localparam int WL = 32;
`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = WL;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [WL-1:0] A = '0;
  logic [WL-1:0] B = '0;
  logic          busy, done, div_zero;
  logic [WL-1:0] Q, R;

  iterative_divider #(.WL(WL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .div_zero(div_zero)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request fixes the answer immediately
  // (plain / and %) and a countdown of the operation latency.
  logic          m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [WL-1:0] m_q = '0, m_r = '0, pq = '0, pr = '0;
  logic          pdz = 1'b0;
  int            m_cnt = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (start && !m_busy) begin
        pq     <= (B == 0) ? '1 : A / B;
        pr     <= (B == 0) ? A  : A % B;
        pdz    <= (B == 0);
        m_cnt  <= (B == 0) ? ZLAT : WL;
        m_busy <= 1'b1;
        m_dz   <= 1'b0;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q <= pq; m_r <= pr; m_dz <= pdz;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, m_busy});
      chk("done", {63'd0, done}, {63'd0, m_done});
      chk("Q", {32'd0, Q}, {32'd0, m_q});
      chk("R", {32'd0, R}, {32'd0, m_r});
      chk("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
    end
  end

  // Waits for done after an accepting edge; returns cycles counted from it.
  task automatic wait_done(output int n, output bit got);
    n = 0; got = 1'b0;
    while (n < WL + 8 && !got) begin
      @(posedge CLK); #1; n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [WL-1:0] a, input logic [WL-1:0] b,
                        input int lat, input logic [WL-1:0] q, input logic [WL-1:0] r,
                        input logic dz);
    int n; bit got;
    @(posedge CLK); #1 start = 1'b1; A = a; B = b;
    @(posedge CLK); #1 start = 1'b0; A = $urandom; B = $urandom;
    wait_done(n, got);
    chk({name, "_latency"}, 64'(n), 64'(lat));
    if (got) begin
      chk({name, "_Q"}, {32'd0, Q}, {32'd0, q});
      chk({name, "_R"}, {32'd0, R}, {32'd0, r});
      chk({name, "_dz"}, {63'd0, div_zero}, {63'd0, dz});
    end
  endtask

  initial begin
    int n; bit got; int dcount;
    logic [WL-1:0] a, b;

    // Reset
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_Q", {32'd0, Q}, 64'd0);
    chk("rst_R", {32'd0, R}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk_en = 1'b1;
    RST = 1'b0;

    // Basic operations and boundaries
    run_op("t1", 32'd100, 32'd7, WL, 32'd14, 32'd2, 1'b0);
    run_op("t2a", 32'hFFFF_FFFF, 32'd1, WL, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("t2b", 32'd5, 32'd9, WL, 32'd0, 32'd5, 1'b0);
    run_op("t3", 32'd1234, 32'd0, ZLAT, 32'hFFFF_FFFF, 32'd1234, 1'b1);

    // Back-to-back: start held through busy and into DONE
    @(posedge CLK); #1 start = 1'b1; A = 32'd100; B = 32'd7;
    @(posedge CLK); #1 A = $urandom; B = $urandom;
    wait_done(n, got);
    chk("t4a_latency", 64'(n), 64'(WL));
    chk("t4a_Q", {32'd0, Q}, 64'd14);
    A = 32'd50; B = 32'd5;
    @(posedge CLK); #1;
    chk("t4_accept_busy", {63'd0, busy}, 64'd1);
    chk("t4_done_drop", {63'd0, done}, 64'd0);
    A = $urandom; B = $urandom;
    n = 0; got = 1'b0;
    while (n < WL + 8 && !got) begin
      @(posedge CLK); #1; n++;
      if (done) got = 1'b1;
      else start = (n < 3) || (n < 20 && (n % 2 == 1));
    end
    start = 1'b0;
    chk("t4b_latency", 64'(n), 64'(WL));
    chk("t4b_Q", {32'd0, Q}, 64'd10);
    chk("t4b_R", {32'd0, R}, 64'd0);

    // Reset in the middle of an operation
    @(posedge CLK); #1 start = 1'b1; A = 32'd1000; B = 32'd3;
    @(posedge CLK); #1 start = 1'b0;
    repeat (9) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_done", {63'd0, done}, 64'd0);
    chk("t5_Q", {32'd0, Q}, 64'd0);
    chk("t5_R", {32'd0, R}, 64'd0);
    dcount = 0;
    repeat (WL + 8) begin
      @(posedge CLK); #1;
      if (done) dcount++;
    end
    chk("t5_no_done", 64'(dcount), 64'd0);
    run_op("t5_fresh", 32'd81, 32'd9, WL, 32'd9, 32'd0, 1'b0);

    // Random operands, nonzero divisor
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (b == 0) b = 32'd1;
      run_op("rand", a, b, WL, a / b, a % b, 1'b0);
      chk("rand_QBR", 64'(Q) * 64'(b) + 64'(R), 64'(a));
      chk("rand_RltB", {63'd0, (R < b)}, 64'd1);
    end

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
